ps2_key_rx: RTL and testbench

- Receives raw PS/2 keyboard clock/data and produces the 11-bit ps2_key word that the key-mapping logic in the arcade top level consumes.
- It is the producer end of that interface, so cores can read a keyboard directly without the hps_io path.
- Handles frame sampling, parity/framing checks, line timeout and the E0/F0 prefix bytes, then emits a toggle-flagged key event.

---
 rtl/ps2_key_rx_pkg.sv | 19 +
 rtl/ps2_key_rx_if.sv | 16 +
 rtl/ps2_key_rx_fsm.sv | 126 ++++++++++++
 rtl/ps2_line_filter.sv | 62 ++++++
 rtl/ps2_key_rx.sv | 63 ++++++
 tb/tb_ps2_key_rx.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ps2_key_rx_pkg.sv
// PS/2 keyboard receiver shared definitions:
// prefix bytes, FSM states and ps2_key field positions.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key event bundle from the PS/2 frame FSM to the
// arcade key-mapping consumer.
interface ps2_key_if;
  logic [10:0] key;
  logic        strobe;
  logic        err;
  logic        busy;

  modport master (
    output key, strobe, err, busy
  );

  modport slave (
    input key, strobe, err, busy
  );
endinterface

// File: rtl/ps2_key_rx_fsm.sv
// PS/2 frame shifter, checker and prefix tracker
// producing toggle-flagged key events.
module ps2_key_rx_fsm
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 12000
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      fall_i,
  input  logic      data_i,
  ps2_key_if.master key_if
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ps2_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [10:0]   sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [10:0]   key_q, key_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;

  logic [7:0] byte_w;
  logic       valid_w;

  assign byte_w  = sh_q[8:1];
  assign valid_w = ~sh_q[0] & sh_q[10] & (^sh_q[9:1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tmo_d   = tmo_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    key_d   = key_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall_i) begin
          sh_d[0] = data_i;
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // An edge in the timeout cycle still counts.
        if (fall_i) begin
          sh_d[cnt_q] = data_i;
          tmo_d       = '0;
          if (cnt_q == 4'd10) state_d = CHECK;
          else                cnt_d   = cnt_q + 4'd1;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b1;
          ext_d   = 1'b0;
          rel_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmo_d   = '0;
        if (!valid_w) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end else if (byte_w == PS2_PREFIX_EXT) begin
          ext_d = 1'b1;
        end else if (byte_w == PS2_PREFIX_REL) begin
          rel_d = 1'b1;
        end else if (byte_w != PS2_PREFIX_PAUSE) begin
          key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
          key_d[KEY_PRESSED] = ~rel_q;
          key_d[KEY_EXT]     = ext_q;
          key_d[7:0]         = byte_w;
          stb_d              = 1'b1;
          ext_d              = 1'b0;
          rel_d              = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      key_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      key_q   <= key_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign key_if.key    = key_q;
  assign key_if.strobe = stb_q;
  assign key_if.err    = err_q;
  assign key_if.busy   = (state_q == SHIFT) ||
                         (state_q == CHECK);

endmodule

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus stability filter for one
// PS/2 line; BYPASS keeps only the synchroniser.
module ps2_line_filter #(
  parameter int CLK_FILTER = 8,
  parameter bit BYPASS     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], line_i};
  end

  if (BYPASS) begin : g_bypass
    assign level_o = sync_q[1];
    assign fall_o  = 1'b0;
  end else begin : g_filt
    localparam int CW = $clog2(CLK_FILTER + 1);

    logic          level_q, level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles the synced line disagrees with the
    // filtered level; any agreement restarts the count.
    always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CW'(CLK_FILTER - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_q <= 1'b1;
        cnt_q   <= '0;
        fall_q  <= 1'b0;
      end else begin
        level_q <= level_d;
        cnt_q   <= cnt_d;
        fall_q  <= level_q & ~level_d;
      end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver producing the 11-bit
// ps2_key word for the arcade key-mapping logic.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err,
  output logic        busy
);

  logic clk_lvl_unused;
  logic clk_fall;
  logic data_lvl;
  logic data_fall_unused;

  ps2_key_if key_if ();

  ps2_line_filter #(
    .CLK_FILTER (CLK_FILTER),
    .BYPASS     (1'b0)
  ) u_clk_filt (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .line_i  (ps2_clk_i),
    .level_o (clk_lvl_unused),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(
    .CLK_FILTER (CLK_FILTER),
    .BYPASS     (1'b1)
  ) u_data_sync (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .line_i  (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  ps2_key_rx_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .fall_i (clk_fall),
    .data_i (data_lvl),
    .key_if (key_if)
  );

  assign ps2_key    = key_if.key;
  assign key_strobe = key_if.strobe;
  assign frame_err  = key_if.err;
  assign busy       = key_if.busy;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised PS/2 frame bench with an event-queue
// reference model of the key word and error pulses.
module tb_ps2_key_rx;
  import ps2_pkg::*;

  localparam int FILT = 8;
  localparam int TMO  = 12000;
  localparam int HALF = 30;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  ps2_key_rx #(
    .CLK_FILTER (FILT),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  ps2_key_if mon ();
  assign mon.key    = ps2_key;
  assign mon.strobe = key_strobe;
  assign mon.err    = frame_err;
  assign mon.busy   = busy;

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_stb = 0;
  int          n_err = 0;
  logic [10:0] shown_key = '0;

  logic [10:0] m_key = '0;
  logic        m_ext = 1'b0;
  logic        m_rel = 1'b0;

  // Every cycle: each pulse must match the next expected
  // event, and the key word must hold between strobes.
  always @(negedge clk_sys) begin
    ev_t e;
    if (!reset_n) begin
      shown_key = '0;
    end else begin
      if (mon.strobe || mon.err) begin
        checks++;
        if (mon.strobe) n_stb++;
        if (mon.err) n_err++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event strobe=%0b err=%0b key=%h",
                   mon.strobe, mon.err, mon.key);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            if (!(mon.err && !mon.strobe)) begin
              errors++;
              $display("FAIL event_kind got strobe=%0b err=%0b want err",
                       mon.strobe, mon.err);
            end
          end else begin
            shown_key = e.key;
            if (!(mon.strobe && !mon.err) || mon.key !== e.key) begin
              errors++;
              $display("FAIL key_event got stb=%0b err=%0b key=%h want key=%h",
                       mon.strobe, mon.err, mon.key, e.key);
            end
          end
        end
      end
      checks++;
      if (mon.key !== shown_key) begin
        errors++;
        $display("FAIL key_hold got %h want %h", mon.key, shown_key);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic p,
                             input logic s, input logic t);
    ev_t e;
    if (s != 1'b0 || t != 1'b1 || ((^b) ^ p) != 1'b1) begin
      e.is_err = 1'b1;
      e.key    = '0;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b != 8'hE1) begin
      m_key    = {~m_key[10], ~m_rel, m_ext, b};
      e.is_err = 1'b0;
      e.key    = m_key;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n,
                           input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data_i = bits[i];
      if (glitch) begin
        wait_cyc(16);
        ps2_clk_i = 1'b0;
        wait_cyc($urandom_range(1, FILT - 3));
        ps2_clk_i = 1'b1;
      end
      wait_cyc(HALF);
      ps2_clk_i = 1'b0;
      wait_cyc(HALF);
      ps2_clk_i = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_start, input bit bad_stop,
                            input bit glitch);
    logic p, s, t;
    p = bad_par ? (^b) : ~(^b);
    s = bad_start;
    t = ~bad_stop;
    model_frame(b, p, s, t);
    send_bits({t, p, b, s}, 11, glitch);
    ps2_data_i = 1'b1;
    wait_cyc(HALF + 20);
    drain("frame_drain");
  endtask

  task automatic frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sb, se;
    logic [7:0] b;
    logic [7:0] pre [3];
    pre[0] = 8'hE0;
    pre[1] = 8'hF0;
    pre[2] = 8'hE1;

    wait_cyc(5);
    @(negedge clk_sys);
    chk("rst_key", 32'(ps2_key), 32'h0);
    chk("rst_pulses", {30'd0, key_strobe, frame_err}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);

    frame(8'h1C);
    chk("make_key", 32'(ps2_key), 32'h61C);
    chk("make_stb", n_stb, 1);
    chk("make_err", n_err, 0);

    frame(8'hF0);
    frame(8'h1C);
    chk("break_key", 32'(ps2_key), 32'h01C);
    chk("break_stb", n_stb, 2);

    frame(8'hE0);
    frame(8'h75);
    chk("ext_make", 32'(ps2_key), 32'h775);
    frame(8'hE0);
    frame(8'hF0);
    frame(8'h75);
    chk("ext_break", 32'(ps2_key), 32'h175);
    chk("ext_stb", n_stb, 4);

    frame(8'hF0);
    send_frame(8'h29, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h29);
    chk("par_key", 32'(ps2_key), 32'h629);
    chk("par_err", n_err, 1);
    chk("par_stb", n_stb, 5);

    begin
      ev_t e;
      e.is_err = 1'b1;
      e.key    = '0;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
    send_bits(11'b000_0010_1100, 5, 1'b0);
    ps2_data_i = 1'b1;
    @(negedge clk_sys);
    chk("busy_mid", 32'(busy), 32'h1);
    wait_cyc(TMO + 10);
    @(negedge clk_sys);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_err", n_err, 2);
    drain("tmo_drain");
    frame(8'h16);
    chk("tmo_next", 32'(ps2_key), 32'h216);

    send_bits(11'b110_0011_1000, 4, 1'b0);
    reset_n = 1'b0;
    exp_q.delete();
    m_key = '0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    wait_cyc(2);
    @(negedge clk_sys);
    chk("mrst_key", 32'(ps2_key), 32'h0);
    chk("mrst_busy", {31'd0, busy}, 32'h0);
    chk("mrst_pulses", {30'd0, key_strobe, frame_err}, 32'h0);
    reset_n = 1'b1;
    ps2_data_i = 1'b1;
    wait_cyc(20);
    frame(8'h1C);
    chk("mrst_next", 32'(ps2_key), 32'h61C);

    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("glitch_key", 32'(ps2_key), 32'h375);
    frame(8'hE0);
    frame(8'h75);
    chk("clean_key", 32'(ps2_key), 32'h775);

    sb = n_stb;
    se = n_err;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) b = pre[$urandom_range(0, 2)];
      else                           b = 8'($urandom);
      send_frame(b,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0);
    end
    checks++;
    if (n_stb + n_err == sb + se) begin
      errors++;
      $display("FAIL rand_activity got no events want some");
    end
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
